// File: rtl/video_fetch_resp_pkg.sv
// Shared definitions for the video fetch responder: default bus widths and FSM encoding.
package video_fetch_resp_pkg;

  localparam int unsigned DEF_ADDR_W = 21;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StSettle = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/video_fetch_resp_if.sv
// Bundle of the address-generator, DRAM-arbiter and pixel-shifter signals seen by the responder.
interface video_fetch_resp_if
  import video_fetch_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] video_addr;
  logic              video_next;
  logic              fetch_en;
  logic              flush;
  logic              dram_req;
  logic [ADDR_W-1:0] dram_addr;
  logic              dram_ack;
  logic              dram_rdstb;
  logic [DATA_W-1:0] dram_rddata;
  logic [DATA_W-1:0] video_data;
  logic              video_valid;
  logic              pix_pop;

  // Environment side: generator, arbiter and shifter.
  modport master (
    output video_addr, fetch_en, flush, dram_ack, dram_rdstb, dram_rddata, pix_pop,
    input  video_next, dram_req, dram_addr, video_data, video_valid
  );

  // Responder side.
  modport slave (
    input  video_addr, fetch_en, flush, dram_ack, dram_rdstb, dram_rddata, pix_pop,
    output video_next, dram_req, dram_addr, video_data, video_valid
  );

endinterface

// File: rtl/video_fetch_fifo.sv
// Small synchronous read-data FIFO with flush; head word is presented combinationally from storage.
module video_fetch_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              valid
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_ok, push_ok;

  assign pop_ok  = pop && (count_q != '0);
  // At full a push is only legal when the head slot is freed in the same cycle.
  assign push_ok = push && !flush && ((count_q != CNT_W'(DEPTH)) || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = rd_ptr_q;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign valid = (count_q != '0);

endmodule

// File: rtl/video_fetch_resp.sv
// Video fetch responder: credit-limited DRAM read issue, in-order return with flush discard.
module video_fetch_resp
  import video_fetch_resp_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  video_fetch_resp_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              load_addr;
  logic [CNT_W-1:0]  out_q, out_d, disc_q, disc_d, fifo_count;
  logic [CNT_W:0]    in_use;
  logic              has_credit, ack, rd_ok, push;

  assign ack   = bus.dram_ack && (state_q == StReq);
  // A strobe with nothing outstanding is a protocol error and is ignored outright.
  assign rd_ok = bus.dram_rdstb && (out_q != '0);

  assign in_use     = {1'b0, fifo_count} + {1'b0, out_q};
  assign has_credit = in_use < (CNT_W + 1)'(FIFO_DEPTH);

  always_comb begin
    state_d   = state_q;
    load_addr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.fetch_en && has_credit) begin
          state_d   = StReq;
          load_addr = 1'b1;
        end
      end
      StReq:    if (bus.dram_ack) state_d = StSettle;
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    out_d  = out_q + CNT_W'(ack) - CNT_W'(rd_ok);
    disc_d = disc_q;
    push   = 1'b0;
    if (rd_ok) begin
      if (disc_q != '0) disc_d = disc_q - 1'b1;
      else              push   = 1'b1;
    end
    // Everything still in flight after this cycle belongs to the old line.
    if (bus.flush) begin
      disc_d = out_d;
      push   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      out_q   <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      if (load_addr) addr_q <= bus.video_addr;
    end
  end

  video_fetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .push      (push),
    .push_data (bus.dram_rddata),
    .pop       (bus.pix_pop),
    .head      (bus.video_data),
    .count     (fifo_count),
    .valid     (bus.video_valid)
  );

  assign bus.dram_req   = (state_q == StReq);
  assign bus.dram_addr  = addr_q;
  assign bus.video_next = (state_q == StSettle);

endmodule

// File: tb/tb_video_fetch_resp.sv
// Directed bench for video_fetch_resp: bench acts as address generator, DRAM and pixel shifter.
module tb_video_fetch_resp;

  localparam int unsigned AW = 21;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst_n;

  video_fetch_resp_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  video_fetch_resp #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Address generator: advances on each video_next, unaffected by the responder reset.
  logic [AW-1:0] gen_addr = '0;
  always @(posedge clk) if (bus.video_next) gen_addr <= gen_addr + 1'b1;
  assign bus.video_addr = gen_addr;

  int vectors = 0;
  int miscompares = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [AW-1:0] inflight[$];
  logic [DW-1:0] expq[$];
  int disc_left = 0;
  int w;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hC3A5;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"},   32'(bus.dram_req),    32'd0);
    check({tag, "_next"},  32'(bus.video_next),  32'd0);
    check({tag, "_valid"}, 32'(bus.video_valid), 32'd0);
    check({tag, "_data"},  32'(bus.video_data),  32'd0);
    check({tag, "_addr"},  32'(bus.dram_addr),   32'd0);
  endtask

  task automatic wait_req(output int waited);
    waited = 0;
    while (!bus.dram_req && waited < 20) begin
      step();
      waited++;
    end
    check("req_seen", 32'(bus.dram_req), 32'd1);
    check("dram_addr", 32'(bus.dram_addr), 32'(exp_addr));
  endtask

  task automatic do_req(input int ack_dly, input bit drop_en, output int waited);
    wait_req(waited);
    if (!bus.dram_req) return;
    if (drop_en) bus.fetch_en = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      step();
      check("req_held", 32'(bus.dram_req), 32'd1);
      check("next_early", 32'(bus.video_next), 32'd0);
    end
    bus.dram_ack = 1'b1;
    step();
    bus.dram_ack = 1'b0;
    check("video_next", 32'(bus.video_next), 32'd1);
    check("req_after_ack", 32'(bus.dram_req), 32'd0);
    inflight.push_back(exp_addr);
    exp_addr++;
  endtask

  task automatic rd_return(input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = inflight.pop_front();
      bus.dram_rdstb  = 1'b1;
      bus.dram_rddata = word_of(a);
      if (disc_left > 0) disc_left--;
      else expq.push_back(word_of(a));
      step();
      bus.dram_rdstb  = 1'b0;
      bus.dram_rddata = '0;
    end
  endtask

  task automatic pop_check();
    check("pop_valid", 32'(bus.video_valid), 32'd1);
    if (expq.size() != 0) check("pop_data", 32'(bus.video_data), 32'(expq.pop_front()));
    bus.pix_pop = 1'b1;
    step();
    bus.pix_pop = 1'b0;
  endtask

  task automatic expect_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("no_req", 32'(bus.dram_req), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    rst_n           = 1'b0;
    bus.fetch_en    = 1'b0;
    bus.flush       = 1'b0;
    bus.dram_ack    = 1'b0;
    bus.dram_rdstb  = 1'b0;
    bus.dram_rddata = '0;
    bus.pix_pop     = 1'b0;
    step();
    step();
    check_zero("reset");
    rst_n = 1'b1;
    step();
    check_zero("post_reset");

    // Back-to-back requests with immediate ack: spacing 3, addresses 0,1,2,3.
    bus.fetch_en = 1'b1;
    do_req(0, 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      do_req(0, 1'b0, w);
      check("req_spacing", 32'(w), 32'd2);
    end
    // Credit exhausted by outstanding reads, then by a full FIFO.
    expect_idle(6);
    rd_return(4);
    expect_idle(3);
    check("full_valid", 32'(bus.video_valid), 32'd1);
    pop_check();
    do_req(0, 1'b0, w);
    check("refill_wait", 32'(w), 32'd1);
    expect_idle(6);

    // Simultaneous push and pop: head advances, occupancy unchanged.
    bus.fetch_en = 1'b0;
    check("pp_data", 32'(bus.video_data), 32'(expq.pop_front()));
    a = inflight.pop_front();
    expq.push_back(word_of(a));
    bus.dram_rdstb  = 1'b1;
    bus.dram_rddata = word_of(a);
    bus.pix_pop     = 1'b1;
    step();
    bus.dram_rdstb  = 1'b0;
    bus.pix_pop     = 1'b0;
    for (int i = 0; i < 3; i++) pop_check();
    check("drained", 32'(bus.video_valid), 32'd0);

    // Pop while empty, then stray strobe with nothing outstanding: both ignored.
    bus.pix_pop = 1'b1;
    step();
    bus.pix_pop = 1'b0;
    check("empty_pop", 32'(bus.video_valid), 32'd0);
    bus.dram_rdstb  = 1'b1;
    bus.dram_rddata = 16'hDEAD;
    step();
    bus.dram_rdstb  = 1'b0;
    check("stray_rdstb", 32'(bus.video_valid), 32'd0);

    // Delayed ack with fetch_en dropped during REQ.
    bus.fetch_en = 1'b1;
    do_req(5, 1'b1, w);
    expect_idle(8);
    rd_return(1);
    pop_check();
    check("t3_empty", 32'(bus.video_valid), 32'd0);

    // Flush with two words buffered, one returning and one acked in the flush cycle.
    bus.fetch_en = 1'b1;
    do_req(0, 1'b0, w);
    do_req(0, 1'b0, w);
    rd_return(2);
    do_req(0, 1'b0, w);
    wait_req(w);
    a = inflight.pop_front();
    bus.dram_ack    = 1'b1;
    bus.flush       = 1'b1;
    bus.dram_rdstb  = 1'b1;
    bus.dram_rddata = word_of(a);
    step();
    bus.dram_ack    = 1'b0;
    bus.flush       = 1'b0;
    bus.dram_rdstb  = 1'b0;
    bus.fetch_en    = 1'b0;
    inflight.push_back(exp_addr);
    exp_addr++;
    expq.delete();
    disc_left = inflight.size();
    check("flush_next", 32'(bus.video_next), 32'd1);
    check("flush_valid", 32'(bus.video_valid), 32'd0);
    rd_return(1);
    check("discarded", 32'(bus.video_valid), 32'd0);
    expect_idle(2);
    bus.fetch_en = 1'b1;
    do_req(0, 1'b0, w);
    bus.fetch_en = 1'b0;
    rd_return(1);
    pop_check();
    check("t4_empty", 32'(bus.video_valid), 32'd0);

    // Reset while in REQ with data buffered and two reads outstanding.
    bus.fetch_en = 1'b1;
    do_req(0, 1'b0, w);
    rd_return(1);
    do_req(0, 1'b0, w);
    do_req(0, 1'b0, w);
    wait_req(w);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    inflight.delete();
    expq.delete();
    disc_left = 0;
    step();
    step();
    rst_n = 1'b1;
    do_req(0, 1'b0, w);
    bus.fetch_en = 1'b0;
    rd_return(1);
    pop_check();
    check("t6_empty", 32'(bus.video_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
